// File: rtl/hello_scroll_ctrl_if.sv
// Control and data bundle between the HELLO scroll controller and its driver.
// Carries run/dir/step/load controls in, registered characters and rotation select out.
interface hello_scroll_ctrl_if;
    logic        run;
    logic        dir;
    logic        step;
    logic        load;
    logic [14:0] chars_in;
    logic [14:0] chars;
    logic [2:0]  sel;
    logic        tick;

    modport master (
        output run, dir, step, load, chars_in,
        input  chars, sel, tick
    );

    modport slave (
        input  run, dir, step, load, chars_in,
        output chars, sel, tick
    );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// Purpose: holds the five HELLO character codes and drives the rotator select, auto or per button press.
// Latency: outputs registered; a Step fall reaches Sel on the 3rd rising edge, a prescaler wrap on its own edge.
// Backpressure: none; Load wins over any coincident advance, which is dropped.
module hello_scroll_ctrl #(
    parameter int DIV   = 50000000,
    parameter int CNT_W = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    hello_scroll_ctrl_if.slave  bus
);

    logic [CNT_W-1:0] cnt;
    logic             s1, s2, s3;
    logic [1:0]       sync_vld;
    logic             armed;
    logic [2:0]       sel_q;
    logic [14:0]      chars_q;
    logic             tick_q;

    logic             wrap;
    logic             press;
    logic             advance;

    always_comb begin
        wrap    = bus.run && (cnt == CNT_W'(DIV - 1));
        press   = armed & s3 & ~s2;
        advance = ~bus.load & (bus.run ? wrap : press);
    end

    // armed stays low until s2 carries a genuine high sample, so a button
    // already held down across reset release cannot fake a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            s1       <= bus.step;
            s2       <= s1;
            s3       <= s2;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & s2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.load || !bus.run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 3'd0;
            chars_q <= 15'h7FFF;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= advance;
            if (bus.load) begin
                sel_q   <= 3'd0;
                chars_q <= bus.chars_in;
            end else if (advance) begin
                sel_q <= bus.dir ? (sel_q - 3'd1) : (sel_q + 3'd1);
            end
        end
    end

    assign bus.sel   = sel_q;
    assign bus.chars = chars_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Table-driven bench for hello_scroll_ctrl at DIV=4; expected outputs queued per driven cycle.
module tb_hello_scroll_ctrl;

    typedef struct {
        logic        run;
        logic        dir;
        logic        step;
        logic        load;
        logic [14:0] ci;
        logic [2:0]  sel;
        logic        tick;
        logic [14:0] chars;
    } vec_t;

    logic clk;
    logic rst_n;
    hello_scroll_ctrl_if bus ();

    hello_scroll_ctrl #(.DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    localparam logic [14:0] C = 15'h7688;
    localparam logic [14:0] X = 15'h0123;
    localparam logic [14:0] N = 15'h2A5B;
    localparam logic [14:0] A = 15'h1A2B;
    localparam logic [14:0] B = 15'h0F0F;
    localparam logic [14:0] D = 15'h7001;

    function automatic void add(logic run, logic dir, logic step, logic load, logic [14:0] ci,
                                logic [2:0] sel, logic tick, logic [14:0] chars);
        vec_t v;
        v.run = run; v.dir = dir; v.step = step; v.load = load; v.ci = ci;
        v.sel = sel; v.tick = tick; v.chars = chars;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [14:0] act, logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        vec_t e;
        bus.run      = v.run;
        bus.dir      = v.dir;
        bus.step     = v.step;
        bus.load     = v.load;
        bus.chars_in = v.ci;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " sel"},   {12'd0, bus.sel},  {12'd0, e.sel});
        chk({tag, " tick"},  {14'd0, bus.tick}, {14'd0, e.tick});
        chk({tag, " chars"}, bus.chars,         e.chars);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // load, then auto increment over a full 7->0 wrap; CharsIn wiggles without Load later on
        add(0, 0, 1, 1, C, 3'd0, 1'b0, C);
        for (int k = 1; k <= 32; k++)
            add(1, 0, 1, 0, (k > 16) ? X : C, 3'((k / 4) % 8), (k % 4) == 0, C);
        // auto decrement 0->7->6
        for (int k = 1; k <= 8; k++)
            add(1, 1, 1, 0, C, 3'((8 - k / 4) % 8), (k % 4) == 0, C);
        // dir flipped mid-count takes effect at the very next wrap
        add(1, 1, 1, 0, C, 3'd6, 1'b0, C);
        add(1, 1, 1, 0, C, 3'd6, 1'b0, C);
        add(1, 0, 1, 0, C, 3'd6, 1'b0, C);
        add(1, 0, 1, 0, C, 3'd7, 1'b1, C);
        // reach Sel=6 with prescaler at 3, then Load on the wrap edge
        for (int k = 1; k <= 3; k++) add(1, 1, 1, 0, C, 3'd7, 1'b0, C);
        add(1, 1, 1, 0, C, 3'd6, 1'b1, C);
        for (int k = 1; k <= 3; k++) add(1, 1, 1, 0, C, 3'd6, 1'b0, C);
        add(1, 1, 1, 1, N, 3'd0, 1'b0, N);
        for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, N, 3'd0, 1'b0, N);
        add(1, 0, 1, 0, N, 3'd1, 1'b1, N);
        // pause at prescaler=2, resume needs a full 4 cycles
        add(1, 0, 1, 0, N, 3'd1, 1'b0, N);
        add(1, 0, 1, 0, N, 3'd1, 1'b0, N);
        for (int k = 1; k <= 5; k++) add(0, 0, 1, 0, N, 3'd1, 1'b0, N);
        for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, N, 3'd1, 1'b0, N);
        add(1, 0, 1, 0, N, 3'd2, 1'b1, N);
        // manual: Step held low 10 cycles gives exactly one step, 3 edges after the fall
        add(0, 0, 0, 0, N, 3'd2, 1'b0, N);
        add(0, 0, 0, 0, N, 3'd2, 1'b0, N);
        add(0, 0, 0, 0, N, 3'd3, 1'b1, N);
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, N, 3'd3, 1'b0, N);
        for (int k = 1; k <= 3; k++) add(0, 0, 1, 0, N, 3'd3, 1'b0, N);
        // three one-cycle low pulses -> Sel+3
        for (int i = 0; i <= 8; i++)
            add(0, 0, (i < 6) ? ((i % 2) == 1) : 1'b1, 0, N,
                3'(3 + ((i < 6 ? i : 6) / 2)), (i == 2) || (i == 4) || (i == 6), N);
        // press while running is ignored
        for (int k = 1; k <= 8; k++)
            add(1, 0, k != 1, 0, N, (k < 4) ? 3'd6 : ((k < 8) ? 3'd7 : 3'd0),
                (k == 4) || (k == 8), N);
        add(0, 0, 1, 0, N, 3'd0, 1'b0, N);
        // Load held high pins Sel at 0 and tracks CharsIn
        for (int k = 1; k <= 4; k++)
            add(1, 1, 1, 0, N, (k < 4) ? 3'd0 : 3'd7, k == 4, N);
        add(1, 1, 1, 1, A, 3'd0, 1'b0, A);
        add(1, 1, 1, 1, B, 3'd0, 1'b0, B);
        add(1, 1, 1, 1, D, 3'd0, 1'b0, D);
        add(0, 0, 1, 0, X, 3'd0, 1'b0, D);
        // walk down to Sel=5 for the asynchronous reset check
        for (int k = 1; k <= 12; k++)
            add(1, 1, 1, 0, D, 3'((8 - k / 4) % 8), (k % 4) == 0, D);

        bus.run = 1'b0; bus.dir = 1'b0; bus.step = 1'b1; bus.load = 1'b0; bus.chars_in = 15'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset sel",   {12'd0, bus.sel},  15'd0);
        chk("reset tick",  {14'd0, bus.tick}, 15'd0);
        chk("reset chars", bus.chars,         15'h7FFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // async reset mid-cycle with Sel=5, Step held low across release
        #2 rst_n = 1'b0;
        #1;
        chk("midreset sel",   {12'd0, bus.sel},  15'd0);
        chk("midreset tick",  {14'd0, bus.tick}, 15'd0);
        chk("midreset chars", bus.chars,         15'h7FFF);
        bus.step = 1'b0;
        bus.run  = 1'b0;
        #2 rst_n = 1'b1;

        v.run = 0; v.dir = 0; v.load = 0; v.ci = D; v.chars = 15'h7FFF;
        v.step = 0; v.sel = 3'd0; v.tick = 0;
        for (int k = 0; k < 6; k++) apply(v, $sformatf("lowrel%0d", k));
        v.step = 1;
        apply(v, "rise0");
        apply(v, "rise1");
        v.step = 0;
        apply(v, "fall0");
        apply(v, "fall1");
        v.sel = 3'd1; v.tick = 1;
        apply(v, "fall2");
        v.step = 1; v.tick = 0;
        apply(v, "after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
